lcu_seq_adder: RTL and testbench
================================

# lcu_seq_adder

Multi-cycle wide adder that reuses one narrow lookahead carry unit across segments. It accepts a wide operand pair over a valid/ready handshake and walks it least-significant segment first, one segment per cycle. The carry-out of each segment is registered and fed in as the carry-in of the next. It sits between operand producers and result consumers where a full-width parallel-prefix adder costs too much area; it is the sequencing controller for the LCU datapath.

## Interface
- `SEG_W`, default 8: segment width in bits, which is also the LCU width. Must be ≥ 2.
- `NSEG`, default 4: number of segments. Must be ≥ 1. Total width `TW = SEG_W*NSEG`.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operand pair available.
- `in_ready`  out  1  block can accept operands.
- `in_a`  in  TW  operand A.
- `in_b`  in  TW  operand B.
- `cin`  in  1  carry-in; present only with `LCU_SEQ_CIN_EN`.
- `out_valid`  out  1  result held on `out_sum`/`out_co`.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  TW  `(A+B+cin) mod 2^TW`.
- `out_co`  out  1  carry out of bit `TW-1`.

## Operation
- FSM states are IDLE, RUN and DONE. Registers: `a_q`, `b_q`, `sum_q`, `carry_q`, `seg_q` (`$clog2(NSEG)` bits, minimum 1).

IDLE:
- `in_ready`=1.
- Accept happens when `in_valid && in_ready`. On accept: latch `a_q`/`b_q`, set `carry_q` = `cin` (0 when the macro is off), set `seg_q`=0, go to RUN.

RUN (one segment per cycle):
- Segment `s = seg_q`, bits `[s*SEG_W +: SEG_W]`.
- `p = a_seg ^ b_seg`.
- `g = a_seg & b_seg`, with `g[0] |= p[0] & carry_q`.
- `lcu_prefix` returns `CO`.
- `sum_seg = p ^ {CO[SEG_W-2:0], carry_q}`, written into `sum_q[s]`.
- `carry_q <= CO[SEG_W-1]`.
- If `seg_q == NSEG-1`: go to DONE. Otherwise `seg_q++`.
- `in_valid` is ignored in this state.

DONE:
- `out_valid`=1; `out_sum`=`sum_q`; `out_co`=`carry_q`.
- On `out_ready`, go to IDLE.
- `in_ready`=0, so a new operand is never accepted in the same cycle as the result is taken.

Arithmetic and boundaries:
- Arithmetic is unsigned and modulo `2^TW`. `out_co` is the true carry of the full sum.
- `NSEG`=1: RUN lasts exactly one cycle.
- Operand inputs may change after accept; only the latched copies are used.

Reset (`rst_n`=0 at an edge):
- state=IDLE, `out_valid`=0, `out_sum`=0, `out_co`=0, `carry_q`=0, `seg_q`=0.
- `in_ready` is 0 while `rst_n` is low and 1 on the first cycle after release.
- Reset in RUN or DONE aborts the operation; no result is produced.

## Timing
- Accept edge = cycle 0. RUN occupies cycles 1..NSEG. `out_valid` rises in cycle NSEG+1 and is registered.
- Minimum initiation interval is NSEG+2 cycles: NSEG RUN cycles, one DONE cycle with `out_ready`=1, and one IDLE cycle.
- Under backpressure, `out_sum`/`out_co`/`out_valid` hold stable until `out_ready`.
- `in_ready` and `out_valid` are decoded from registered state only; there is no combinational path from `in_valid` or `out_ready` to any output.
- Critical path is one `SEG_W`-bit prefix tree plus a carry mux.

## Configuration
- `LCU_SEQ_CIN_EN` defined: the `cin` port exists and is sampled at accept into `carry_q`.
- Not defined: no `cin` port; `carry_q` is loaded with 0 at accept. All other behaviour is identical.

## Structure
- Shared package `lcu_pkg` holds:
  - the FSM state enum typedef;
  - a `LCU_SEG_IDX_W(NSEG)` width helper function;
  - the default parameter constants.
- Sub-module `lcu_prefix #(WIDTH)`: combinational Kogge-Stone group generate/propagate prefix. Ports `P`, `G`, `CO`. Instantiated once with `WIDTH=SEG_W`.

## Test plan
All scenarios use `SEG_W`=8, `NSEG`=4.
- 0x12345678 + 0x11111111, `out_ready`=1 → `out_sum`=0x23456789, `out_co`=0, `out_valid` high exactly 5 cycles after accept for 1 cycle.
- 0xFFFFFFFF + 0x00000001 → `out_sum`=0x00000000, `out_co`=1; confirms carry ripples through all 4 segments.
- `LCU_SEQ_CIN_EN`, 0x000000FF + 0x00000000 with `cin`=1 → `out_sum`=0x00000100, `out_co`=0. Macro off: same operands → 0x000000FF.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid` → `out_sum`/`out_co` stable, `in_ready`=0 throughout, `in_valid` pulses ignored; result consumed on the first `out_ready`=1.
- Reset mid-RUN (assert `rst_n`=0 in cycle 2):
  - `out_valid` never rises; all outputs read 0.
  - A new 0x00000001 + 0x00000001 accepted after release → 0x00000002.
- Randomised back-to-back stream of 1000 pairs with random `out_ready` → every result matches the 33-bit reference sum, results come out in order, and the initiation interval is never below 6 cycles.

Source files
------------

// File: rtl/lcu_seq_adder_pkg.sv
// lcu_pkg: shared FSM state type, segment-index width helper and default sizes for lcu_seq_adder
package lcu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SEG_W_DEF = 8;
  localparam int NSEG_DEF = 4;
  function automatic int LCU_SEG_IDX_W(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lcu_seq_adder_if.sv
// lcu_seq_adder_if: operand/result handshake bundle; cin exists only when LCU_SEQ_CIN_EN is defined
interface lcu_seq_adder_if #(parameter int TW = 32);
  logic in_valid, in_ready, out_valid, out_ready, out_co;
  logic [TW-1:0] in_a, in_b, out_sum;
`ifdef LCU_SEQ_CIN_EN
  logic cin;
`endif
  modport master (
`ifdef LCU_SEQ_CIN_EN
    output cin,
`endif
    output in_valid, in_a, in_b, out_ready,
    input in_ready, out_valid, out_sum, out_co
  );
  modport slave (
`ifdef LCU_SEQ_CIN_EN
    input cin,
`endif
    input in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_co
  );
endinterface

// File: rtl/lcu_seq_adder_prefix.sv
// lcu_prefix: combinational Kogge-Stone group generate/propagate prefix, CO[i] = carry out of bit i
module lcu_prefix #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] G,
  output logic [WIDTH-1:0] CO
);
  logic [WIDTH-1:0] g, p;
  // descending i keeps i-k at the previous level's value within a stage
  always_comb begin
    g = G;
    p = P;
    for (int k = 1; k < WIDTH; k = k * 2)
      for (int i = WIDTH - 1; i >= k; i--) begin
        g[i] = g[i] | (p[i] & g[i-k]);
        p[i] = p[i] & p[i-k];
      end
    CO = g;
  end
endmodule

// File: rtl/lcu_seq_adder.sv
// lcu_seq_adder: segment-serial wide adder reusing one LCU per cycle; LCU_SEQ_CIN_EN enables the cin input
module lcu_seq_adder import lcu_pkg::*; #(
  parameter int SEG_W = SEG_W_DEF,
  parameter int NSEG = NSEG_DEF
) (
  input logic clk,
  input logic rst_n,
  lcu_seq_adder_if.slave bus
);
  localparam int TW = SEG_W * NSEG;
  localparam int IW = LCU_SEG_IDX_W(NSEG);
  state_t state_q, state_d;
  logic [TW-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0] seg_q, seg_d;
  logic carry_q, carry_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d, cin_w;
  logic [SEG_W-1:0] a_seg, b_seg, p, g, co;
`ifdef LCU_SEQ_CIN_EN
  assign cin_w = bus.cin;
`else
  assign cin_w = 1'b0;
`endif
  lcu_prefix #(.WIDTH(SEG_W)) u_prefix (.P(p), .G(g), .CO(co));
  always_comb begin
    a_seg = a_q[int'(seg_q)*SEG_W +: SEG_W];
    b_seg = b_q[int'(seg_q)*SEG_W +: SEG_W];
    p = a_seg ^ b_seg;
    g = a_seg & b_seg;
    g[0] = g[0] | (p[0] & carry_q);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    sum_d = sum_q;
    carry_d = carry_q;
    seg_d = seg_q;
    case (state_q)
      IDLE: if (bus.in_valid && in_ready_q) begin
        a_d = bus.in_a;
        b_d = bus.in_b;
        carry_d = cin_w;
        seg_d = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[int'(seg_q)*SEG_W +: SEG_W] = p ^ {co[SEG_W-2:0], carry_q};
        carry_d = co[SEG_W-1];
        state_d = seg_q == IW'(NSEG - 1) ? DONE : RUN;
        seg_d = seg_q == IW'(NSEG - 1) ? seg_q : seg_q + 1'b1;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == IDLE;
    out_valid_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q <= '0;
      carry_q <= 1'b0;
      seg_q <= '0;
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      seg_q <= seg_d;
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum = sum_q;
  assign bus.out_co = carry_q;
endmodule

// File: tb/tb_lcu_seq_adder.sv
// tb_lcu_seq_adder: randomized self-checking bench for lcu_seq_adder (SEG_W=8, NSEG=4)
module tb_lcu_seq_adder;
`ifdef LCU_SEQ_CIN_EN
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic cin_drv;
  int n_tests = 0;
  int n_fail = 0;
  lcu_seq_adder_if #(.TW(32)) bus ();
`ifdef LCU_SEQ_CIN_EN
  assign bus.cin = cin_drv;
`endif
  lcu_seq_adder #(.SEG_W(8), .NSEG(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [32:0] model(input logic [31:0] a, b, input logic c);
    return 33'(a) + 33'(b) + 33'(CIN_EN ? c : 1'b0);
  endfunction

  // entered at a negedge; returns {out_co,out_sum} and the cycle index at which out_valid was first seen
  task automatic do_op(input logic [31:0] a, b, input logic c, output logic [32:0] r, output int lat);
    int w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    if (bus.in_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL accept_wait: in_ready=%b required 1", bus.in_ready);
    end
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; cin_drv = c;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_a = $urandom; bus.in_b = $urandom; cin_drv = $urandom_range(0, 1);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    r = {bus.out_co, bus.out_sum};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_a = '0; bus.in_b = '0; cin_drv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_tests++; if ({bus.out_co, bus.out_sum} !== 33'h0) begin n_fail++; $display("FAIL reset_out: got %h expected 0", {bus.out_co, bus.out_sum}); end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    logic [32:0] r; int lat;
    bus.out_ready = 1'b1;
    do_op(32'h12345678, 32'h11111111, 1'b0, r, lat);
    n_tests++; if (r !== 33'h023456789) begin n_fail++; $display("FAIL basic_sum: got %h expected %h", r, 33'h023456789); end
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d expected 5", lat); end
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: out_valid=%b expected 0", bus.out_valid); end
  endtask

  task automatic test_full_carry();
    logic [32:0] r; int lat;
    bus.out_ready = 1'b1;
    do_op(32'hFFFFFFFF, 32'h00000001, 1'b0, r, lat);
    n_tests++; if (r !== 33'h100000000) begin n_fail++; $display("FAIL full_carry: got %h expected %h", r, 33'h100000000); end
    @(negedge clk);
  endtask

  task automatic test_cin();
    logic [32:0] r, e; int lat;
    e = CIN_EN ? 33'h000000100 : 33'h0000000FF;
    bus.out_ready = 1'b1;
    do_op(32'h000000FF, 32'h00000000, 1'b1, r, lat);
    n_tests++; if (r !== e) begin n_fail++; $display("FAIL cin_sum: got %h expected %h", r, e); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [32:0] r, e; int lat; logic [31:0] a, b; logic c;
    a = $urandom; b = $urandom; c = $urandom_range(0, 1);
    e = model(a, b, c);
    bus.out_ready = 1'b0;
    do_op(a, b, c, r, lat);
    n_tests++; if (r !== e) begin n_fail++; $display("FAIL bp_first: got %h expected %h", r, e); end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = $urandom_range(0, 1); bus.in_a = $urandom; bus.in_b = $urandom;
      @(negedge clk);
      n_tests++;
      if (bus.out_valid !== 1'b1 || {bus.out_co, bus.out_sum} !== e || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b out=%h expected valid=1 ready=0 out=%h", i, bus.out_valid, bus.in_ready, {bus.out_co, bus.out_sum}, e);
      end
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_consume: valid=%b ready=%b expected valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [32:0] r; int lat; bit seen = 0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_a = 32'hDEADBEEF; bus.in_b = 32'h01234567;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_co, bus.out_sum} !== 35'h0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h expected 0", {bus.in_ready, bus.out_valid, bus.out_co, bus.out_sum});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1;
    end
    n_tests++; if (seen) begin n_fail++; $display("FAIL mid_reset_no_result: out_valid rose, expected 0"); end
    do_op(32'h00000001, 32'h00000001, 1'b0, r, lat);
    n_tests++; if (r !== 33'h2) begin n_fail++; $display("FAIL mid_reset_next: got %h expected 2", r); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [32:0] q[$];
    logic [32:0] e;
    int sent = 0, got = 0, cyc = 0, last = -1;
    bit pend = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    while (got < 1000 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      bus.out_ready = $urandom_range(0, 1);
      if (!pend) begin
        bus.in_valid = 1'b0;
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          bus.in_valid = 1'b1; bus.in_a = $urandom; bus.in_b = $urandom; cin_drv = $urandom_range(0, 1);
          pend = 1;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra: unexpected result %h", {bus.out_co, bus.out_sum});
        end else begin
          e = q.pop_front();
          if ({bus.out_co, bus.out_sum} !== e) begin
            n_fail++; $display("FAIL stream_sum[%0d]: got %h expected %h", got, {bus.out_co, bus.out_sum}, e);
          end
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(bus.in_a, bus.in_b, cin_drv));
        if (last >= 0) begin
          n_tests++;
          if (cyc - last < 6) begin n_fail++; $display("FAIL stream_ii: got %0d expected >= 6", cyc - last); end
        end
        last = cyc; pend = 0; sent++;
      end
    end
    if (got < 1000) begin n_tests++; n_fail++; $display("FAIL stream_timeout: got %0d results expected 1000", got); end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_carry();
    test_cin();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
